sseg_scan_ctrl: RTL and testbench

SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

---
 rtl/sseg_pkg.sv | 25 ++
 rtl/sseg_decode.sv | 39 +++
 rtl/sseg_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Seven-segment code constants (bit 6 = g ... bit 0 = a, active-low) and the segment-vector type.
package sseg_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/sseg_decode.sv
// Combinational nibble to segment decoder; A-F show as a dash unless hex_mode is set.
module sseg_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  input  logic       blank,
  output seg_t       seg
);

  // nibble lookup with blank override
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (nibble)
        4'h0:    seg = SEG_0;
        4'h1:    seg = SEG_1;
        4'h2:    seg = SEG_2;
        4'h3:    seg = SEG_3;
        4'h4:    seg = SEG_4;
        4'h5:    seg = SEG_5;
        4'h6:    seg = SEG_6;
        4'h7:    seg = SEG_7;
        4'h8:    seg = SEG_8;
        4'h9:    seg = SEG_9;
        4'hA:    seg = hex_mode ? SEG_A : SEG_DASH;
        4'hB:    seg = hex_mode ? SEG_B : SEG_DASH;
        4'hC:    seg = hex_mode ? SEG_C : SEG_DASH;
        4'hD:    seg = hex_mode ? SEG_D : SEG_DASH;
        4'hE:    seg = hex_mode ? SEG_E : SEG_DASH;
        4'hF:    seg = hex_mode ? SEG_F : SEG_DASH;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with frame-synchronous shadow update.
// Optional anode PWM dimming when SSEG_BRIGHTNESS_EN is defined.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 50000,
  parameter int BRIGHT_W   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
`ifdef SSEG_BRIGHTNESS_EN
  input  logic [BRIGHT_W-1:0]     brightness,
`endif
  output seg_t                    seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int PRESC_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_MAX   = IDX_W'(NUM_DIGITS - 1);

  logic [PRESC_W-1:0]      presc_r;
  logic [IDX_W-1:0]        idx_r;
  logic                    pending_r;
  logic [4*NUM_DIGITS-1:0] shadow_dig_r;
  logic [NUM_DIGITS-1:0]   shadow_dp_r;
  logic                    new_frame_r;

  logic                    tick_s;
  logic                    boundary_s;
  logic [3:0]              nib_s;
  logic                    dp_sel_s;
  logic                    blank_s;
  logic                    upper_zero_s;
  logic [NUM_DIGITS-1:0]   an_sel_s;
  logic                    an_on_s;
  seg_t                    seg_dec_s;

  assign tick_s     = (presc_r == PRESC_MAX);
  assign boundary_s = tick_s && (idx_r == IDX_MAX);

  // prescaler, digit index, pending load and shadow capture
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc_r      <= {PRESC_W{1'b0}};
      idx_r        <= {IDX_W{1'b0}};
      pending_r    <= 1'b0;
      shadow_dig_r <= {(4*NUM_DIGITS){1'b0}};
      shadow_dp_r  <= {NUM_DIGITS{1'b0}};
      new_frame_r  <= 1'b1;
    end else begin
      presc_r     <= tick_s ? {PRESC_W{1'b0}} : presc_r + 1'b1;
      new_frame_r <= boundary_s;
      if (tick_s) begin
        idx_r <= (idx_r == IDX_MAX) ? {IDX_W{1'b0}} : idx_r + 1'b1;
      end
      if (boundary_s) begin
        // a load arriving on the boundary cycle itself is captured here too
        if (pending_r || load) begin
          shadow_dig_r <= digits;
          shadow_dp_r  <= dp_in;
        end
        pending_r <= 1'b0;
      end else if (load) begin
        pending_r <= 1'b1;
      end
    end
  end

  // select the scanned digit and decide leading-zero blanking from the shadow copy
  always_comb begin
    nib_s        = 4'h0;
    dp_sel_s     = 1'b0;
    blank_s      = 1'b0;
    upper_zero_s = 1'b1;
    an_sel_s     = {NUM_DIGITS{1'b1}};
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      if (idx_r == IDX_W'(k)) begin
        nib_s       = shadow_dig_r[4*k +: 4];
        dp_sel_s    = shadow_dp_r[k];
        an_sel_s[k] = 1'b0;
        blank_s     = blank_lz && upper_zero_s && (k > 0) && (shadow_dig_r[4*k +: 4] == 4'h0);
      end else begin
        an_sel_s[k] = 1'b1;
      end
      upper_zero_s = upper_zero_s && (shadow_dig_r[4*k +: 4] == 4'h0);
    end
  end

  sseg_decode u_decode (
    .nibble   (nib_s),
    .hex_mode (hex_mode),
    .blank    (blank_s),
    .seg      (seg_dec_s)
  );

`ifdef SSEG_BRIGHTNESS_EN
  logic [BRIGHT_W-1:0] pwm_cnt_r;

  // free-running dimming counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pwm_cnt_r <= {BRIGHT_W{1'b0}};
    end else begin
      pwm_cnt_r <= pwm_cnt_r + 1'b1;
    end
  end

  assign an_on_s = (pwm_cnt_r <= brightness);
`else
  localparam logic [BRIGHT_W-1:0] BRIGHT_FULL = {BRIGHT_W{1'b1}};

  // without dimming the selected anode runs at full brightness
  assign an_on_s = &BRIGHT_FULL;
`endif

  // registered display outputs, one clock behind the index
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      seg         <= SEG_BLANK;
      dp          <= 1'b1;
      an          <= {NUM_DIGITS{1'b1}};
      frame_start <= 1'b0;
    end else begin
      seg         <= seg_dec_s;
      dp          <= ~dp_sel_s;
      an          <= an_on_s ? an_sel_s : {NUM_DIGITS{1'b1}};
      frame_start <= new_frame_r;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Randomized self-checking bench for sseg_scan_ctrl against a time-based reference model.
module tb_sseg_scan_ctrl;
  import sseg_pkg::*;

  localparam int ND     = 4;
  localparam int TD     = 4;
  localparam int BW     = 4;
  localparam int PERIOD = ND * TD;

  logic          clock = 1'b0;
  logic          reset;
  logic [15:0]   digits;
  logic [3:0]    dp_in;
  logic          load, hex_mode, blank_lz;
  logic [BW-1:0] brightness;
  seg_t          seg;
  logic          dp;
  logic [3:0]    an;
  logic          frame_start;

  int tests_run = 0;
  int tests_failed = 0;

  // model state: edges since reset release, shadow copy, pending flag
  int          n;
  logic [15:0] m_shadow;
  logic [3:0]  m_sdp;
  bit          m_pend;
  logic [12:0] exp_out;

  always #5 clock = ~clock;

  sseg_scan_ctrl #(.NUM_DIGITS(ND), .TICK_DIV(TD), .BRIGHT_W(BW)) dut (
    .clock       (clock),
    .reset       (reset),
    .digits      (digits),
    .dp_in       (dp_in),
    .load        (load),
    .hex_mode    (hex_mode),
    .blank_lz    (blank_lz),
`ifdef SSEG_BRIGHTNESS_EN
    .brightness  (brightness),
`endif
    .seg         (seg),
    .dp          (dp),
    .an          (an),
    .frame_start (frame_start)
  );

  function automatic logic [6:0] dec_ref(input logic [3:0] v, input logic hm);
    logic [6:0] tab [16];
    tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
            7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    if (v < 4'd10 || hm) return tab[v];
    return 7'b0111111;
  endfunction

  function automatic logic [12:0] observed();
    return {seg, dp, an, frame_start};
  endfunction

  // Predict the outputs after the coming edge, advance one clock, then update the model.
  task automatic step();
    logic ld;
    logic [15:0] dig;
    logic [3:0] dpi, a;
    logic hm, bl;
    logic [6:0] s;
    int idx;
    ld = load; dig = digits; dpi = dp_in; hm = hex_mode; bl = blank_lz;
    idx = (n / TD) % ND;
    if (bl && idx > 0 && (m_shadow >> (4 * idx)) == 16'd0) s = 7'b1111111;
    else s = dec_ref(m_shadow[idx*4 +: 4], hm);
    a = 4'b1111;
    a[idx] = 1'b0;
`ifdef SSEG_BRIGHTNESS_EN
    if ((n % 16) > int'(brightness)) a = 4'b1111;
`endif
    exp_out = {s, ~m_sdp[idx], a, (n % PERIOD) == 0};
    @(posedge clock);
    if ((n + 1) % PERIOD == 0) begin
      if (m_pend || ld) begin
        m_shadow = dig;
        m_sdp = dpi;
      end
      m_pend = 1'b0;
    end else if (ld) begin
      m_pend = 1'b1;
    end
    n++;
    #1;
  endtask

  task automatic model_reset();
    n = 0; m_shadow = 16'h0; m_sdp = 4'h0; m_pend = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; digits = 16'h0; dp_in = 4'h0;
    hex_mode = 1'b0; blank_lz = 1'b0; brightness = 4'hF;
    @(posedge clock); #1;
    tests_run++;
    if (observed() !== 13'b1111111_1_1111_0) begin
      tests_failed++;
      $display("FAIL reset_state got %b exp %b", observed(), 13'b1111111_1_1111_0);
    end
    reset = 1'b0;
    model_reset();
    step();
    tests_run++;
    if (observed() !== exp_out || an !== 4'b1110 || frame_start !== 1'b1) begin
      tests_failed++;
      $display("FAIL first_slot got %b exp %b", observed(), exp_out);
    end
  endtask

  task automatic test_load_display();
    bit seen4 = 1'b0, seen1 = 1'b0;
    digits = 16'h1234; dp_in = 4'b0101; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      step();
      tests_run++;
      if (observed() !== exp_out) begin
        tests_failed++;
        $display("FAIL load_display cyc=%0d got %b exp %b", i, observed(), exp_out);
      end
      if (i >= PERIOD && an === 4'b1110) seen4 = (seg === 7'b0011001);
      if (i >= PERIOD && an === 4'b0111) seen1 = (seg === 7'b1111001);
    end
    tests_run++;
    if (!(seen4 && seen1)) begin
      tests_failed++;
      $display("FAIL load_1234_codes got d0ok=%0d d3ok=%0d exp 1 1", seen4, seen1);
    end
  endtask

  task automatic test_no_tear();
    for (int i = 0; i < 5; i++) step();
    digits = 16'h9999; dp_in = 4'b1111;
    for (int i = 0; i < 3 * PERIOD; i++) begin
      step();
      tests_run++;
      if (observed() !== exp_out) begin
        tests_failed++;
        $display("FAIL no_tear cyc=%0d got %b exp %b", i, observed(), exp_out);
      end
    end
  endtask

  task automatic test_hex_mode();
    digits = 16'h000A; dp_in = 4'h0; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 4 * PERIOD; i++) begin
      hex_mode = 1'($urandom_range(0, 1));
      step();
      tests_run++;
      if (observed() !== exp_out) begin
        tests_failed++;
        $display("FAIL hex_mode cyc=%0d hm=%0d got %b exp %b", i, hex_mode, observed(), exp_out);
      end
    end
    hex_mode = 1'b0;
  endtask

  task automatic test_blank_lz();
    logic [15:0] pats [3] = '{16'h0050, 16'h0000, 16'h0103};
    blank_lz = 1'b1;
    foreach (pats[p]) begin
      digits = pats[p]; dp_in = 4'($urandom); load = 1'b1;
      step();
      load = 1'b0;
      for (int i = 0; i < 2 * PERIOD + 4; i++) begin
        step();
        tests_run++;
        if (observed() !== exp_out) begin
          tests_failed++;
          $display("FAIL blank_lz pat=%h cyc=%0d got %b exp %b", pats[p], i, observed(), exp_out);
        end
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3 * PERIOD; i++) begin
      load = 1'b1; digits = 16'($urandom); dp_in = 4'($urandom);
      step();
      tests_run++;
      if (observed() !== exp_out) begin
        tests_failed++;
        $display("FAIL back_to_back cyc=%0d got %b exp %b", i, observed(), exp_out);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      load = ($urandom_range(0, 9) == 0);
      digits = 16'($urandom); dp_in = 4'($urandom);
      hex_mode = 1'($urandom_range(0, 1));
      blank_lz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) digits[15:8] = 8'h00;
      step();
      tests_run++;
      if (observed() !== exp_out) begin
        tests_failed++;
        $display("FAIL random cyc=%0d got %b exp %b", i, observed(), exp_out);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_reset_midframe();
    bit found = 1'b0;
    digits = 16'h5678; dp_in = 4'hF; load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 2 * PERIOD && !found; i++) begin
      step();
      found = (exp_out[4:1] == 4'b1011) && (n % PERIOD) < PERIOD - TD;
    end
    tests_run++;
    if (!found || an !== 4'b1011) begin
      tests_failed++;
      $display("FAIL reset_mid_reach got an=%b exp an=1011", an);
    end
    #2 reset = 1'b1;
    #1;
    tests_run++;
    if (observed() !== 13'b1111111_1_1111_0) begin
      tests_failed++;
      $display("FAIL reset_mid_async got %b exp %b", observed(), 13'b1111111_1_1111_0);
    end
    @(posedge clock); #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 3 * PERIOD; i++) begin
      step();
      tests_run++;
      if (observed() !== exp_out) begin
        tests_failed++;
        $display("FAIL reset_mid_restart cyc=%0d got %b exp %b", i, observed(), exp_out);
      end
    end
  endtask

`ifdef SSEG_BRIGHTNESS_EN
  task automatic test_brightness();
    logic [BW-1:0] lv [3] = '{4'h0, 4'hF, 4'h5};
    foreach (lv[b]) begin
      brightness = lv[b];
      for (int i = 0; i < 48; i++) begin
        step();
        tests_run++;
        if (observed() !== exp_out) begin
          tests_failed++;
          $display("FAIL brightness lv=%h cyc=%0d got %b exp %b", lv[b], i, observed(), exp_out);
        end
      end
    end
    brightness = 4'hF;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_display();
    test_no_tear();
    test_hex_mode();
    test_blank_lz();
    test_back_to_back();
    test_random();
    test_reset_midframe();
`ifdef SSEG_BRIGHTNESS_EN
    test_brightness();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
